// File: rtl/ysyx_22041752_divider.sv
// ysyx_22041752_divider: multi-cycle restoring radix-2 integer divider.
// Produces RISC-V DIV/DIVU/REM/REMU results, one quotient bit per clock.
// Optional macro YSYX_22041752_DIV_FASTPATH_EN: divide-by-zero and signed
// overflow are resolved at accept and skip the iterative phase.
//
// Handshakes: a request transfers on a rising edge where div_valid and
// div_ready are both high; a result transfers on a rising edge where
// out_valid and out_ready are both high. out_valid, once high, stays high
// with stable quotient/remainder until that transfer (or flush/reset).
module ysyx_22041752_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_r;      // partial remainder
    logic [WIDTH-1:0] quo_sh;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvsr;       // |divisor|
    logic             neg_q;
    logic             neg_r;
    logic             force_zero;
    logic             force_ovf;

    logic             in_dividend_neg;
    logic             in_divisor_neg;
    logic [WIDTH-1:0] in_dividend_abs;
    logic [WIDTH-1:0] in_divisor_abs;
    logic             in_div_zero;
    logic             in_ovf;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] sub;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;

    assign div_ready = (state == S_IDLE);
    assign dbg_state = state;

    // Operand conditioning at accept: signs, magnitudes and special cases.
    always_comb begin
        in_dividend_neg = div_signed & dividend[WIDTH-1];
        in_divisor_neg  = div_signed & divisor[WIDTH-1];
        in_dividend_abs = in_dividend_neg ? (~dividend + 1'b1) : dividend;
        in_divisor_abs  = in_divisor_neg  ? (~divisor + 1'b1)  : divisor;
        in_div_zero     = (divisor == '0);
        in_ovf          = div_signed && (dividend == MIN_NEG) && (divisor == '1);
    end

    // One restoring step: shift in the next dividend bit and trial-subtract
    // via inverted divisor plus carry-in; the carry-out means no borrow.
    always_comb begin
        r_shift   = {rem_r, quo_sh[WIDTH-1]};
        sub       = {1'b0, r_shift} + {1'b0, ~{1'b0, dvsr}} + (WIDTH+2)'(1);
        no_borrow = sub[WIDTH+1];
        rem_next  = no_borrow ? WIDTH'(sub[WIDTH:0]) : WIDTH'(r_shift);
    end

    // Control FSM and datapath registers; flush overrides every transition.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            count      <= '0;
            out_valid  <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            rem_r      <= '0;
            quo_sh     <= '0;
            dvsr       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            force_zero <= 1'b0;
            force_ovf  <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_valid) begin
                        rem_r      <= '0;
                        quo_sh     <= in_dividend_abs;
                        dvsr       <= in_divisor_abs;
                        neg_q      <= in_dividend_neg ^ in_divisor_neg;
                        neg_r      <= in_dividend_neg;
                        force_zero <= in_div_zero;
                        force_ovf  <= in_ovf;
                        count      <= CNT_TOP;
`ifdef YSYX_22041752_DIV_FASTPATH_EN
                        if (in_div_zero || in_ovf) begin
                            quotient  <= in_div_zero ? '1 : dividend;
                            remainder <= in_div_zero ? dividend : '0;
                            state     <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    rem_r  <= rem_next;
                    quo_sh <= {quo_sh[WIDTH-2:0], no_borrow};
                    count  <= count - CW'(1);
                    if (count == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // With a zero divisor every step keeps r', so rem_r ends
                    // as |dividend| and the sign fix restores the dividend.
                    if (force_zero) begin
                        quotient <= '1;
                    end else if (force_ovf) begin
                        quotient <= MIN_NEG;
                    end else begin
                        quotient <= neg_q ? (~quo_sh + 1'b1) : quo_sh;
                    end
                    if (force_ovf) begin
                        remainder <= '0;
                    end else begin
                        remainder <= neg_r ? (~rem_r + 1'b1) : rem_r;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    // out_valid is registered one edge after entering DONE.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041752_divider.sv
// Testbench for ysyx_22041752_divider (WIDTH=64): directed vector table,
// randomized operations against an arithmetic reference model, and
// hand-written backpressure / flush / async-reset sequences.
module tb_ysyx_22041752_divider;

    localparam int W = 64;
    localparam logic [W-1:0] MIN = 64'h8000_0000_0000_0000;

    logic         clk;
    logic         resetn;
    logic         flush;
    logic         div_valid;
    logic         div_ready;
    logic         div_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[12];

    ysyx_22041752_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .dbg_state  (dbg_state)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: RISC-V division rules in plain arithmetic.
    function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn && a == MIN && b == '1) begin
            q = a;
            r = '0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef YSYX_22041752_DIV_FASTPATH_EN
        if (b == '0 || (sgn && a == MIN && b == '1)) return 1;
`endif
        return W + 2;
    endfunction

    // Present a request; it is accepted on the following rising edge.
    // Operand inputs are scrambled afterwards since they must not matter.
    task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        div_valid  = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        div_signed = 1'($urandom_range(0, 1));
        dividend   = {$urandom, $urandom};
        divisor    = {$urandom, $urandom};
    endtask

    // Count edges after accept until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        div_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("take_ready", {63'd0, div_ready}, 64'd1);
        check("take_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_and_check(input string tag, input logic sgn, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat;
        start_op(sgn, a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(sgn, a, b)));
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        take();
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        int           lat;
        int           seen;

        vecs[0]  = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2};
        vecs[1]  = '{1'b1, -64'd100, 64'd7, -64'd14, -64'd2};
        vecs[2]  = '{1'b0, 64'h1234, 64'd0, '1, 64'h1234};
        vecs[3]  = '{1'b1, MIN, '1, MIN, 64'd0};
        vecs[4]  = '{1'b1, 64'd100, -64'd7, -64'd14, 64'd2};
        vecs[5]  = '{1'b1, -64'd100, -64'd7, 64'd14, -64'd2};
        vecs[6]  = '{1'b1, -64'd5, 64'd0, '1, -64'd5};
        vecs[7]  = '{1'b0, '1, 64'd1, '1, 64'd0};
        vecs[8]  = '{1'b0, 64'd0, 64'd5, 64'd0, 64'd0};
        vecs[9]  = '{1'b0, '1, MIN, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[10] = '{1'b1, MIN, 64'd1, MIN, 64'd0};
        vecs[11] = '{1'b0, 64'd7, 64'd100, 64'd0, 64'd7};

        // Reset block
        resetn     = 1'b0;
        flush      = 1'b0;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, div_ready}, 64'd1);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_q", quotient, 64'd0);
        check("rst_r", remainder, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
        end

        // Randomized operations vs reference model; div_valid is left
        // randomly asserted while busy and must be ignored.
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a = MIN;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 64'($urandom_range(1, 20));
                2: b = '1;
                3: b = {$urandom, $urandom};
                4: b = {$urandom, $urandom} >> $urandom_range(1, 62);
                default: b = -64'($urandom_range(1, 1000));
            endcase
            ref_div(sgn, a, b, eq, er);
            start_op(sgn, a, b);
            div_valid = 1'($urandom_range(0, 1));
            wait_valid(lat);
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat(sgn, a, b)));
            check($sformatf("rnd%0d_q", i), quotient, eq);
            check($sformatf("rnd%0d_r", i), remainder, er);
            take();
        end

        // Backpressure: results hold while out_ready is low
        start_op(1'b1, -64'd1000, 64'd33);
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'(W + 2));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_ready", {63'd0, div_ready}, 64'd0);
            check("bp_q", quotient, -64'd30);
            check("bp_r", remainder, -64'd10);
        end
        take();

        // Flush on cycle 20 of an operation
        start_op(1'b0, 64'd123456, 64'd789);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("fl_busy", {63'd0, div_ready}, 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_ready", {63'd0, div_ready}, 64'd1);
        check("fl_valid", {63'd0, out_valid}, 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("fl_no_valid", 64'(seen), 64'd0);

        // Flush together with out_ready in DONE: dropped, stale results kept
        start_op(1'b0, 64'd50, 64'd6);
        wait_valid(lat);
        check("fd_q", quotient, 64'd8);
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b0;
        check("fd_ready", {63'd0, div_ready}, 64'd1);
        check("fd_valid", {63'd0, out_valid}, 64'd0);
        check("fd_stale_q", quotient, 64'd8);
        check("fd_stale_r", remainder, 64'd2);

        // Asynchronous reset mid-CALC
        start_op(1'b0, 64'd1000, 64'd3);
        repeat (10) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("ar_ready", {63'd0, div_ready}, 64'd1);
        check("ar_valid", {63'd0, out_valid}, 64'd0);
        check("ar_q", quotient, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_and_check("ar_after", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
